// File: rtl/bit_serial_alu_ctrl_pkg.sv
// Package bsalu_pkg: shared types and constants for the bit-serial ALU sequencer.
//   bsalu_state_e  : controller FSM states (idle, running bits, result held)
//   BS_MODE_ARITH  : slice mode selecting the arithmetic path
//   BS_MODE_LOGIC  : slice mode selecting the logic path
package bsalu_pkg;

    typedef enum logic [1:0] {
        BS_IDLE,
        BS_RUN,
        BS_DONE
    } bsalu_state_e;

    localparam logic BS_MODE_ARITH = 1'b0;
    localparam logic BS_MODE_LOGIC = 1'b1;

endpackage

// File: rtl/bit_serial_alu_ctrl_if.sv
// Interface bsalu_if: groups the request, slice and result signals of the
// bit-serial ALU sequencer.
//   req_*  : operation request (valid/ready) from the issue logic
//   slc_*  : one-bit operands/controls to the external slice and its result/carry
//   res_*  : assembled result word (valid/ready) to the consumer
// Modports:
//   slave  : the sequencer's view
//   master : the surrounding environment's view (issue logic, slice, consumer)
// Optional: BSALU_FLAGS_EN adds res_zero and res_ovf.
interface bsalu_if #(
    parameter int WIDTH = 8
);
    logic             req_valid;
    logic             req_ready;
    logic [WIDTH-1:0] req_op1;
    logic [WIDTH-1:0] req_op2;
    logic             req_cin;
    logic [2:0]       req_opsel;
    logic             req_mode;

    logic             slc_op1;
    logic             slc_op2;
    logic             slc_cin;
    logic [2:0]       slc_opsel;
    logic             slc_mode;
    logic             slc_result;
    logic             slc_cout;

    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_data;
    logic             res_cout;
`ifdef BSALU_FLAGS_EN
    logic             res_zero;
    logic             res_ovf;
`endif

    modport slave (
        input  req_valid, req_op1, req_op2, req_cin, req_opsel, req_mode,
        output req_ready,
        output slc_op1, slc_op2, slc_cin, slc_opsel, slc_mode,
        input  slc_result, slc_cout,
`ifdef BSALU_FLAGS_EN
        output res_zero, res_ovf,
`endif
        output res_valid, res_data, res_cout,
        input  res_ready
    );

    modport master (
        output req_valid, req_op1, req_op2, req_cin, req_opsel, req_mode,
        input  req_ready,
        input  slc_op1, slc_op2, slc_cin, slc_opsel, slc_mode,
        output slc_result, slc_cout,
`ifdef BSALU_FLAGS_EN
        input  res_zero, res_ovf,
`endif
        input  res_valid, res_data, res_cout,
        output res_ready
    );

endinterface

// File: rtl/bit_serial_alu_ctrl_shreg.sv
// bsalu_shreg: right-shifting register with parallel load.
//   clk        : clock, rising edge
//   rst_n      : synchronous active-low reset, clears the register
//   load       : parallel load of load_data (has priority over shift)
//   load_data  : WIDTH-bit parallel load value
//   shift      : shift right by one, serial_in enters at the MSB
//   serial_in  : bit shifted into the MSB
//   serial_out : current LSB
//   data       : current register contents
module bsalu_shreg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             shift,
    input  logic             serial_in,
    output logic             serial_out,
    output logic [WIDTH-1:0] data
);

    logic [WIDTH-1:0] sr_reg;
    logic [WIDTH-1:0] sr_next;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            // Each bit takes its upper neighbour on a shift; the MSB takes serial_in.
            if (gi == WIDTH - 1) begin : g_msb
                assign sr_next[gi] = load  ? load_data[gi] :
                                     shift ? serial_in     : sr_reg[gi];
            end else begin : g_low
                assign sr_next[gi] = load  ? load_data[gi] :
                                     shift ? sr_reg[gi+1]  : sr_reg[gi];
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sr_reg <= '0;
        end else begin
            sr_reg <= sr_next;
        end
    end

    assign serial_out = sr_reg[0];
    assign data       = sr_reg;

endmodule

// File: rtl/bit_serial_alu_ctrl.sv
// bit_serial_alu_ctrl: sequences an external combinational 1-bit ALU slice
// across a WIDTH-bit operation, LSB first, feeding the slice carry-out back
// as the next bit's carry-in, and returns the assembled word.
// Ports:
//   clk   : clock, all state updates on the rising edge
//   rst_n : synchronous active-low reset (aborts any operation in progress)
//   bus   : bsalu_if.slave -- request (req_*), slice (slc_*), result (res_*)
// Parameter WIDTH: operand/result width, 2..64.
// Optional: BSALU_FLAGS_EN adds res_zero / res_ovf, valid with res_valid.
// Timing: accept edge, then WIDTH RUN cycles; res_valid rises WIDTH edges
// after the accept edge. DONE always returns to IDLE before a new accept.
module bit_serial_alu_ctrl
    import bsalu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic   clk,
    input  logic   rst_n,
    bsalu_if.slave bus
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    bsalu_state_e state_reg, state_next;

    logic [CNT_W-1:0] cnt_reg;
    logic             carry_reg;
    logic [2:0]       opsel_reg;
    logic             mode_reg;
    logic             res_cout_reg;

    // FSM decode
    logic             accept;
    logic             run_en;
    logic             last_bit;
    logic             req_ready;
    logic             res_valid;
    logic             slc_op1;
    logic             slc_op2;
    logic             slc_cin;
    logic [2:0]       slc_opsel;
    logic             slc_mode;

    // Shift register taps
    logic             op1_bit;
    logic             op2_bit;
    logic [WIDTH-1:0] op1_word;
    logic [WIDTH-1:0] op2_word;
    logic [WIDTH-1:0] res_word;
    logic             res_serial;

    // ------------------------------------------------------------------
    // Operand and result shift registers
    // ------------------------------------------------------------------
    bsalu_shreg #(.WIDTH(WIDTH)) u_op1_sr (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (accept),
        .load_data  (bus.req_op1),
        .shift      (run_en),
        .serial_in  (1'b0),
        .serial_out (op1_bit),
        .data       (op1_word)
    );

    bsalu_shreg #(.WIDTH(WIDTH)) u_op2_sr (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (accept),
        .load_data  (bus.req_op2),
        .shift      (run_en),
        .serial_in  (1'b0),
        .serial_out (op2_bit),
        .data       (op2_word)
    );

    // Result bits enter at the MSB, so after WIDTH shifts bit 0 has
    // reached position 0. Cleared on accept so no stale bits survive.
    bsalu_shreg #(.WIDTH(WIDTH)) u_res_sr (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (accept),
        .load_data  ('0),
        .shift      (run_en),
        .serial_in  (bus.slc_result),
        .serial_out (res_serial),
        .data       (res_word)
    );

    // Parallel views of the operand registers and the serial tap of the
    // result register are not needed by the sequencer.
    logic unused_shreg_taps;
    assign unused_shreg_taps = ^{op1_word, op2_word, res_serial};

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= BS_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        accept     = 1'b0;
        run_en     = 1'b0;
        last_bit   = 1'b0;
        req_ready  = 1'b0;
        res_valid  = 1'b0;
        slc_op1    = 1'b0;
        slc_op2    = 1'b0;
        slc_cin    = 1'b0;
        slc_opsel  = 3'b000;
        slc_mode   = 1'b0;

        case (state_reg)
            BS_IDLE: begin
                req_ready = 1'b1;
                if (bus.req_valid) begin
                    accept     = 1'b1;
                    state_next = BS_RUN;
                end
            end
            BS_RUN: begin
                run_en    = 1'b1;
                slc_op1   = op1_bit;
                slc_op2   = op2_bit;
                slc_cin   = carry_reg;
                slc_opsel = opsel_reg;
                slc_mode  = mode_reg;
                if (cnt_reg == CNT_LAST) begin
                    last_bit   = 1'b1;
                    state_next = BS_DONE;
                end
            end
            BS_DONE: begin
                res_valid = 1'b1;
                // No accept here even with req_valid high: IDLE is visited first.
                if (bus.res_ready) begin
                    state_next = BS_IDLE;
                end
            end
            default: begin
                state_next = BS_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Bit counter, carry chain and per-operation control registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_reg      <= '0;
            carry_reg    <= 1'b0;
            opsel_reg    <= 3'b000;
            mode_reg     <= BS_MODE_ARITH;
            res_cout_reg <= 1'b0;
        end else if (accept) begin
            cnt_reg   <= '0;
            carry_reg <= bus.req_cin;
            opsel_reg <= bus.req_opsel;
            mode_reg  <= bus.req_mode ? BS_MODE_LOGIC : BS_MODE_ARITH;
        end else if (run_en) begin
            // Slice carry-out becomes the next bit's carry-in, in both modes.
            carry_reg <= bus.slc_cout;
            if (last_bit) begin
                cnt_reg      <= '0;
                res_cout_reg <= bus.slc_cout;
            end else begin
                cnt_reg <= cnt_reg + CNT_W'(1);
            end
        end
    end

`ifdef BSALU_FLAGS_EN
    logic zero_reg;
    logic ovf_reg;

    // Captured on the last bit: the full result word is the shift-register
    // contents with the final slice bit entering at the top, and carry_reg
    // still holds the carry into the MSB.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            zero_reg <= 1'b0;
            ovf_reg  <= 1'b0;
        end else if (last_bit) begin
            zero_reg <= ({bus.slc_result, res_word[WIDTH-1:1]} == '0);
            ovf_reg  <= (mode_reg == BS_MODE_ARITH) ? (carry_reg ^ bus.slc_cout) : 1'b0;
        end
    end

    assign bus.res_zero = zero_reg;
    assign bus.res_ovf  = ovf_reg;
`endif

    // ------------------------------------------------------------------
    // Interface outputs
    // ------------------------------------------------------------------
    assign bus.req_ready = req_ready;
    assign bus.res_valid = res_valid;
    assign bus.res_data  = res_word;
    assign bus.res_cout  = res_cout_reg;
    assign bus.slc_op1   = slc_op1;
    assign bus.slc_op2   = slc_op2;
    assign bus.slc_cin   = slc_cin;
    assign bus.slc_opsel = slc_opsel;
    assign bus.slc_mode  = slc_mode;

endmodule

// File: tb/tb_bit_serial_alu_ctrl.sv
// Testbench for bit_serial_alu_ctrl (WIDTH=8) with a behavioural 1-bit slice:
//   arith mode: opsel 000 = add, opsel 001 = subtract (op1 + ~op2 + cin)
//   logic mode: opsel 001 = AND, 010 = OR, 011 = XOR (carry-out 0)
// Directed steps in one initial block; optional flag checks under BSALU_FLAGS_EN.
module tb_bit_serial_alu_ctrl;

    localparam int WIDTH = 8;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    int   cycles;

    always #5 clk = ~clk;

    bsalu_if #(.WIDTH(WIDTH)) bus ();

    bit_serial_alu_ctrl #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Behavioural slice
    logic slc_b;
    always_comb begin
        slc_b          = bus.slc_op2;
        bus.slc_result = 1'b0;
        bus.slc_cout   = 1'b0;
        if (bus.slc_mode == 1'b0) begin
            slc_b          = (bus.slc_opsel == 3'b001) ? ~bus.slc_op2 : bus.slc_op2;
            bus.slc_result = bus.slc_op1 ^ slc_b ^ bus.slc_cin;
            bus.slc_cout   = (bus.slc_op1 & slc_b) | (bus.slc_op1 & bus.slc_cin) | (slc_b & bus.slc_cin);
        end else begin
            case (bus.slc_opsel)
                3'b001:  bus.slc_result = bus.slc_op1 & bus.slc_op2;
                3'b010:  bus.slc_result = bus.slc_op1 | bus.slc_op2;
                3'b011:  bus.slc_result = bus.slc_op1 ^ bus.slc_op2;
                default: bus.slc_result = 1'b0;
            endcase
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] slc_vec();
        return {bus.slc_op1, bus.slc_op2, bus.slc_cin, bus.slc_opsel, bus.slc_mode};
    endfunction

    task automatic drive_req(input logic [7:0] op1, input logic [7:0] op2,
                             input logic cin, input logic [2:0] opsel, input logic mode);
        bus.req_op1   = op1;
        bus.req_op2   = op2;
        bus.req_cin   = cin;
        bus.req_opsel = opsel;
        bus.req_mode  = mode;
    endtask

    // Present a request in IDLE and take the accept edge.
    task automatic start_op(input logic [7:0] op1, input logic [7:0] op2,
                            input logic cin, input logic [2:0] opsel, input logic mode);
        check("accept_ready", bus.req_ready, 1'b1);
        drive_req(op1, op2, cin, opsel, mode);
        bus.req_valid = 1'b1;
        tick();
        bus.req_valid = 1'b0;
    endtask

    // Count RUN cycles until res_valid (bounded), checking controls each cycle.
    task automatic wait_done(input logic [2:0] opsel, input logic mode, output int n);
        n = 0;
        while (!bus.res_valid && n < 20) begin
            check("run_req_ready", bus.req_ready, 1'b0);
            check("run_slc_opsel", bus.slc_opsel, opsel);
            check("run_slc_mode", bus.slc_mode, mode);
            tick();
            n++;
        end
    endtask

    task automatic finish_op(input string name, input logic [7:0] exp_data, input logic exp_cout);
        check({name, "_latency"}, cycles, WIDTH);
        check({name, "_valid"}, bus.res_valid, 1'b1);
        check({name, "_data"}, bus.res_data, exp_data);
        check({name, "_cout"}, bus.res_cout, exp_cout);
        check({name, "_slc_idle"}, slc_vec(), 8'h00);
        $display("op %s: data=0x%02h cout=%0d latency=%0d", name, bus.res_data, bus.res_cout, cycles);
    endtask

    task automatic release_result();
        bus.res_ready = 1'b1;
        tick();
        bus.res_ready = 1'b0;
        check("release_valid", bus.res_valid, 1'b0);
        check("release_ready", bus.req_ready, 1'b1);
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.req_valid = 1'b0;
        bus.res_ready = 1'b0;
        drive_req(8'h00, 8'h00, 1'b0, 3'b000, 1'b0);
        tick();
        tick();

        // Reset state
        check("rst_req_ready", bus.req_ready, 1'b1);
        check("rst_res_valid", bus.res_valid, 1'b0);
        check("rst_res_data", bus.res_data, 8'h00);
        check("rst_res_cout", bus.res_cout, 1'b0);
        check("rst_slc", slc_vec(), 8'h00);
`ifdef BSALU_FLAGS_EN
        check("rst_zero", bus.res_zero, 1'b0);
        check("rst_ovf", bus.res_ovf, 1'b0);
`endif
        $display("reset: req_ready=%0d res_valid=%0d", bus.req_ready, bus.res_valid);
        rst_n = 1'b1;
        tick();

        // 1: 0x5A + 0x33 = 0x8D
        start_op(8'h5A, 8'h33, 1'b0, 3'b000, 1'b0);
        wait_done(3'b000, 1'b0, cycles);
        finish_op("add_5a_33", 8'h8D, 1'b0);
        release_result();

        // 2: 0xFF + 0x01 = 0x00 carry 1
        start_op(8'hFF, 8'h01, 1'b0, 3'b000, 1'b0);
        wait_done(3'b000, 1'b0, cycles);
        finish_op("add_ff_01", 8'h00, 1'b1);
`ifdef BSALU_FLAGS_EN
        check("add_ff_01_zero", bus.res_zero, 1'b1);
        check("add_ff_01_ovf", bus.res_ovf, 1'b0);
`endif
        release_result();

        // 0x7F + 0x01 = 0x80: signed overflow, no carry
        start_op(8'h7F, 8'h01, 1'b0, 3'b000, 1'b0);
        wait_done(3'b000, 1'b0, cycles);
        finish_op("add_7f_01", 8'h80, 1'b0);
`ifdef BSALU_FLAGS_EN
        check("add_7f_01_zero", bus.res_zero, 1'b0);
        check("add_7f_01_ovf", bus.res_ovf, 1'b1);
`endif
        release_result();

        // 0x10 - 0x01 = 0x0F (0x10 + 0xFE + 1, carry 1)
        start_op(8'h10, 8'h01, 1'b1, 3'b001, 1'b0);
        wait_done(3'b001, 1'b0, cycles);
        finish_op("sub_10_01", 8'h0F, 1'b1);
`ifdef BSALU_FLAGS_EN
        check("sub_10_01_ovf", bus.res_ovf, 1'b0);
`endif
        release_result();

        // 3: logic AND 0xF0 & 0x3C = 0x30
        start_op(8'hF0, 8'h3C, 1'b0, 3'b001, 1'b1);
        wait_done(3'b001, 1'b1, cycles);
        finish_op("and_f0_3c", 8'h30, 1'b0);
`ifdef BSALU_FLAGS_EN
        check("and_f0_3c_ovf", bus.res_ovf, 1'b0);
`endif
        release_result();

        // 4: back-to-back, 0x12 + 0x34 + 1 = 0x47, request held, res_ready high
        drive_req(8'h12, 8'h34, 1'b1, 3'b000, 1'b0);
        bus.req_valid = 1'b1;
        bus.res_ready = 1'b1;
        check("b2b_ready0", bus.req_ready, 1'b1);
        tick();
        wait_done(3'b000, 1'b0, cycles);
        finish_op("b2b_first", 8'h47, 1'b0);
        tick();
        check("b2b_idle_ready", bus.req_ready, 1'b1);
        check("b2b_idle_valid", bus.res_valid, 1'b0);
        tick();
        check("b2b_second_accept", bus.req_ready, 1'b0);
        bus.req_valid = 1'b0;
        wait_done(3'b000, 1'b0, cycles);
        finish_op("b2b_second", 8'h47, 1'b0);
        tick();
        bus.res_ready = 1'b0;
        check("b2b_end_ready", bus.req_ready, 1'b1);

        // 5: backpressure, 0x0F + 0x01 = 0x10, another request waiting
        start_op(8'h0F, 8'h01, 1'b0, 3'b000, 1'b0);
        wait_done(3'b000, 1'b0, cycles);
        finish_op("bp_add", 8'h10, 1'b0);
        drive_req(8'hAA, 8'h55, 1'b0, 3'b000, 1'b0);
        bus.req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_valid", bus.res_valid, 1'b1);
            check("bp_data", bus.res_data, 8'h10);
            check("bp_req_ready", bus.req_ready, 1'b0);
        end
        bus.res_ready = 1'b1;
        tick();
        bus.req_valid = 1'b0;
        bus.res_ready = 1'b0;
        check("bp_release_valid", bus.res_valid, 1'b0);
        check("bp_release_ready", bus.req_ready, 1'b1);
        $display("op bp_release: req_ready=%0d", bus.req_ready);

        // 6: reset mid-RUN (bit counter at 3)
        start_op(8'h5A, 8'h33, 1'b0, 3'b000, 1'b0);
        tick();
        tick();
        tick();
        check("abort_in_run", bus.req_ready, 1'b0);
        rst_n = 1'b0;
        tick();
        check("abort_req_ready", bus.req_ready, 1'b1);
        check("abort_res_valid", bus.res_valid, 1'b0);
        check("abort_res_data", bus.res_data, 8'h00);
        check("abort_res_cout", bus.res_cout, 1'b0);
        check("abort_slc", slc_vec(), 8'h00);
        $display("op abort: req_ready=%0d res_data=0x%02h", bus.req_ready, bus.res_data);
        rst_n = 1'b1;
        tick();

        // Recovery after abort: 0x01 + 0x01 = 0x02
        start_op(8'h01, 8'h01, 1'b0, 3'b000, 1'b0);
        wait_done(3'b000, 1'b0, cycles);
        finish_op("recover", 8'h02, 1'b0);
        release_result();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
